// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : multicycle_control_unit_if
// Brief     : Opcode/memory handshake inputs and datapath control outputs
//             of the multicycle control unit.
// Revision  : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       instr_op;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic             reg_write;
    logic             reg_dst;
    logic [1:0]       pc_source;
    logic [1:0]       alu_op;
    logic [1:0]       alu_src_b;
    logic [3:0]       state;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output instr_op, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, alu_src_a, reg_write, reg_dst, pc_source, alu_op,
               alu_src_b, state, instr_done, illegal_op, instr_count
    );

    modport slave (
        input  instr_op, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, alu_src_a, reg_write, reg_dst, pc_source, alu_op,
               alu_src_b, state, instr_done, illegal_op, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Moore control FSM for a multicycle MIPS-style datapath.
//            Build option: define CTRL_JUMP_EN to support the j instruction.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int CNT_W = 16
) (
    input  wire                      clk,
    input  wire                      rst,
    multicycle_control_unit_if.slave bus
);
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
`ifdef CTRL_JUMP_EN
    localparam logic [5:0] c_OP_J     = 6'b000010;
`endif

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_R_WB     = 4'd7,
        ST_BRANCH   = 4'd8,
`ifdef CTRL_JUMP_EN
        ST_JUMP     = 4'd9,
`endif
        ST_ADDI_EX  = 4'd10,
        ST_ADDI_WB  = 4'd11
    } state_t;

    // fetch/wr_done mark strobes that are later qualified by mem_ready
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       done;
        logic       fetch;
        logic       wr_done;
    } ctrl_t;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch = 1'b1; end
            ST_DECODE:   c.alu_src_b = 2'b11;
            ST_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ST_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            ST_MEM_WB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            ST_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.wr_done = 1'b1; end
            ST_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            ST_R_WB:     begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.done          = 1'b1;
            end
`ifdef CTRL_JUMP_EN
            ST_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.done = 1'b1; end
`endif
            ST_ADDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ST_ADDI_WB:  begin c.reg_write = 1'b1; c.done = 1'b1; end
            default:     c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        case (op)
            c_OP_RTYPE, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_ADDI: ok = 1'b1;
`ifdef CTRL_JUMP_EN
            c_OP_J:  ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic state_t next_of(input state_t s, input logic [5:0] op, input logic ready);
        state_t n;
        n = ST_FETCH;
        case (s)
            ST_FETCH: n = ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op)
                    c_OP_RTYPE:       n = ST_EXECUTE;
                    c_OP_LW, c_OP_SW: n = ST_MEM_ADDR;
                    c_OP_BEQ:         n = ST_BRANCH;
                    c_OP_ADDI:        n = ST_ADDI_EX;
`ifdef CTRL_JUMP_EN
                    c_OP_J:           n = ST_JUMP;
`endif
                    default:          n = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: n = (op == c_OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   n = ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   n = ready ? ST_FETCH : ST_MEM_WR;
            ST_EXECUTE:  n = ST_R_WB;
            ST_ADDI_EX:  n = ST_ADDI_WB;
            // write-back, branch, jump and unused encodings all return to fetch
            default:     n = ST_FETCH;
        endcase
        return n;
    endfunction

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_count;
    state_t           w_next;
    logic             w_fetch_go;
    logic             w_instr_done;

    assign w_next       = next_of(r_state, bus.instr_op, bus.mem_ready);
    assign w_fetch_go   = r_ctrl.fetch & bus.mem_ready;
    assign w_instr_done = r_ctrl.done | (r_ctrl.wr_done & bus.mem_ready);

    // Outputs are decoded from the next state so they are valid from the first
    // cycle of each state without a combinational path from the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_ctrl  <= decode(ST_FETCH);
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode(w_next);
            if (w_instr_done) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.pc_write      = r_ctrl.pc_write | w_fetch_go;
    assign bus.ir_write      = w_fetch_go;
    assign bus.pc_write_cond = r_ctrl.pc_write_cond;
    assign bus.i_or_d        = r_ctrl.i_or_d;
    assign bus.mem_read      = r_ctrl.mem_read;
    assign bus.mem_write     = r_ctrl.mem_write;
    assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
    assign bus.alu_src_a     = r_ctrl.alu_src_a;
    assign bus.reg_write     = r_ctrl.reg_write;
    assign bus.reg_dst       = r_ctrl.reg_dst;
    assign bus.pc_source     = r_ctrl.pc_source;
    assign bus.alu_op        = r_ctrl.alu_op;
    assign bus.alu_src_b     = r_ctrl.alu_src_b;
    assign bus.state         = r_state;
    assign bus.instr_done    = w_instr_done;
    assign bus.illegal_op    = (r_state == ST_DECODE) && !is_legal(bus.instr_op);
    assign bus.instr_count   = r_count;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Directed self-checking bench for multicycle_control_unit
//            (16-bit and 4-bit counter instances driven in lockstep).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;
    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       ready;
    int         errors = 0;
    int         checks = 0;
    int         exp_count = 0;

    multicycle_control_unit_if #(.CNT_W(16)) bus16 ();
    multicycle_control_unit_if #(.CNT_W(4))  bus4 ();

    assign bus16.instr_op  = op;
    assign bus16.mem_ready = ready;
    assign bus4.instr_op   = op;
    assign bus4.mem_ready  = ready;

    multicycle_control_unit #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus16.slave));
    multicycle_control_unit #(.CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ready = 1'b0; op = c_OP_R;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus16.state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus16.state); end
        checks++; if (bus16.instr_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus16.instr_count); end
        checks++; if (bus16.mem_read !== 1'b1 || bus16.alu_src_b !== 2'b01) begin errors++; $display("FAIL reset_fetch_decode: got mem_read=%0b alu_src_b=%0b want 1/01", bus16.mem_read, bus16.alu_src_b); end
        checks++; if ({bus16.ir_write, bus16.pc_write, bus16.reg_write, bus16.mem_write, bus16.i_or_d, bus16.pc_write_cond,
                       bus16.alu_src_a, bus16.alu_op, bus16.pc_source, bus16.instr_done, bus16.illegal_op} !== 13'd0) begin
            errors++; $display("FAIL reset_others_zero: some strobe nonzero while mem_ready=0");
        end
        ready = 1'b1; #1;
        checks++; if (bus16.ir_write !== 1'b1 || bus16.pc_write !== 1'b1) begin errors++; $display("FAIL reset_fetch_strobes: got ir_write=%0b pc_write=%0b want 1/1", bus16.ir_write, bus16.pc_write); end
        step;
        checks++; if (bus16.state !== 4'd0 || bus16.reg_write !== 1'b0) begin errors++; $display("FAIL reset_held: got state=%0d reg_write=%0b want 0/0", bus16.state, bus16.reg_write); end
        rst = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_lw;
        logic [3:0] st [0:4];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 5; i++) begin
            op = c_OP_LW; ready = 1'b1; #1;
            checks++; if (bus16.state !== st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus16.state, st[i]); end
            checks++; if (bus16.reg_write !== (st[i] == 4'd4) || bus16.mem_to_reg !== (st[i] == 4'd4)) begin
                errors++; $display("FAIL lw_wb[%0d]: got reg_write=%0b mem_to_reg=%0b", i, bus16.reg_write, bus16.mem_to_reg);
            end
            step;
        end
        exp_count++;
        checks++; if (bus16.state !== 4'd0 || bus16.instr_count !== 16'(exp_count)) begin
            errors++; $display("FAIL lw_end: got state=%0d count=%0d want 0/%0d", bus16.state, bus16.instr_count, exp_count);
        end
    endtask

    task automatic test_sw_stall;
        logic [3:0] st  [0:6];
        logic       rdy [0:6];
        logic       dn  [0:6];
        logic       mw  [0:6];
        st  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        dn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        mw  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            op = c_OP_SW; ready = rdy[i]; #1;
            checks++; if (bus16.state !== st[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus16.state, st[i]); end
            checks++; if (bus16.mem_write !== mw[i] || bus16.instr_done !== dn[i]) begin
                errors++; $display("FAIL sw_strobes[%0d]: got mem_write=%0b instr_done=%0b want %0b/%0b", i, bus16.mem_write, bus16.instr_done, mw[i], dn[i]);
            end
            step;
        end
        ready = 1'b1;
        exp_count++;
        checks++; if (bus16.state !== 4'd0 || bus16.instr_count !== 16'(exp_count)) begin
            errors++; $display("FAIL sw_end: got state=%0d count=%0d want 0/%0d", bus16.state, bus16.instr_count, exp_count);
        end
    endtask

    task automatic test_illegal;
        for (int i = 0; i < 2; i++) begin
            op = c_OP_BAD; ready = 1'b1; #1;
            checks++; if (bus16.state !== 4'(i) || bus16.illegal_op !== (i == 1)) begin
                errors++; $display("FAIL illegal_state[%0d]: got state=%0d illegal_op=%0b", i, bus16.state, bus16.illegal_op);
            end
            checks++; if ({bus16.reg_write, bus16.mem_write, bus16.instr_done} !== 3'b000) begin
                errors++; $display("FAIL illegal_strobes[%0d]: got reg_write/mem_write/instr_done=%0b want 000", i, {bus16.reg_write, bus16.mem_write, bus16.instr_done});
            end
            step;
        end
        checks++; if (bus16.state !== 4'd0 || bus16.illegal_op !== 1'b0 || bus16.instr_count !== 16'(exp_count)) begin
            errors++; $display("FAIL illegal_end: got state=%0d illegal_op=%0b count=%0d want 0/0/%0d", bus16.state, bus16.illegal_op, bus16.instr_count, exp_count);
        end
    endtask

    task automatic test_alu_branch;
        logic [5:0] ops [0:2];
        int         len [0:2];
        logic [3:0] seq [0:2][0:3];
        ops = '{c_OP_R, c_OP_BEQ, c_OP_ADDI};
        len = '{4, 3, 4};
        seq = '{'{4'd0, 4'd1, 4'd6, 4'd7}, '{4'd0, 4'd1, 4'd8, 4'd0}, '{4'd0, 4'd1, 4'd10, 4'd11}};
        // two stalled fetch cycles ahead of the first instruction
        for (int s = 0; s < 2; s++) begin
            op = c_OP_R; ready = 1'b0; #1;
            checks++; if (bus16.state !== 4'd0 || bus16.ir_write !== 1'b0 || bus16.pc_write !== 1'b0) begin
                errors++; $display("FAIL fetch_stall[%0d]: got state=%0d ir_write=%0b pc_write=%0b want 0/0/0", s, bus16.state, bus16.ir_write, bus16.pc_write);
            end
            step;
        end
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < len[j]; i++) begin
                op = ops[j]; ready = 1'b1; #1;
                checks++; if (bus16.state !== seq[j][i]) begin errors++; $display("FAIL alu_state[%0d][%0d]: got %0d want %0d", j, i, bus16.state, seq[j][i]); end
                checks++; if (bus16.instr_done !== (i == len[j] - 1)) begin errors++; $display("FAIL alu_done[%0d][%0d]: got %0b", j, i, bus16.instr_done); end
                if (seq[j][i] == 4'd6) begin
                    checks++; if (bus16.alu_op !== 2'b10 || bus16.alu_src_a !== 1'b1) begin errors++; $display("FAIL exec_sel: got alu_op=%0b alu_src_a=%0b want 10/1", bus16.alu_op, bus16.alu_src_a); end
                end
                if (seq[j][i] == 4'd7) begin
                    checks++; if (bus16.reg_dst !== 1'b1 || bus16.reg_write !== 1'b1 || bus16.mem_to_reg !== 1'b0) begin errors++; $display("FAIL r_wb: got reg_dst=%0b reg_write=%0b mem_to_reg=%0b want 1/1/0", bus16.reg_dst, bus16.reg_write, bus16.mem_to_reg); end
                end
                if (seq[j][i] == 4'd8) begin
                    checks++; if (bus16.pc_write_cond !== 1'b1 || bus16.pc_source !== 2'b01 || bus16.alu_op !== 2'b01 || bus16.pc_write !== 1'b0) begin
                        errors++; $display("FAIL branch_sel: got pc_write_cond=%0b pc_source=%0b alu_op=%0b pc_write=%0b want 1/01/01/0", bus16.pc_write_cond, bus16.pc_source, bus16.alu_op, bus16.pc_write);
                    end
                end
                if (seq[j][i] == 4'd10) begin
                    checks++; if (bus16.alu_src_b !== 2'b10 || bus16.alu_src_a !== 1'b1 || bus16.alu_op !== 2'b00) begin errors++; $display("FAIL addi_ex: got alu_src_b=%0b alu_src_a=%0b alu_op=%0b want 10/1/00", bus16.alu_src_b, bus16.alu_src_a, bus16.alu_op); end
                end
                if (seq[j][i] == 4'd11) begin
                    checks++; if (bus16.reg_write !== 1'b1 || bus16.reg_dst !== 1'b0 || bus16.mem_to_reg !== 1'b0) begin errors++; $display("FAIL addi_wb: got reg_write=%0b reg_dst=%0b mem_to_reg=%0b want 1/0/0", bus16.reg_write, bus16.reg_dst, bus16.mem_to_reg); end
                end
                step;
            end
            exp_count++;
        end
        checks++; if (bus16.state !== 4'd0 || bus16.instr_count !== 16'(exp_count)) begin
            errors++; $display("FAIL alu_end: got state=%0d count=%0d want 0/%0d", bus16.state, bus16.instr_count, exp_count);
        end
    endtask

    task automatic test_jump;
        for (int i = 0; i < 2; i++) begin
            op = c_OP_J; ready = 1'b1; #1;
            checks++; if (bus16.state !== 4'(i)) begin errors++; $display("FAIL jump_state[%0d]: got %0d want %0d", i, bus16.state, i); end
`ifndef CTRL_JUMP_EN
            checks++; if (bus16.illegal_op !== (i == 1)) begin errors++; $display("FAIL jump_illegal[%0d]: got %0b", i, bus16.illegal_op); end
`endif
            step;
        end
`ifdef CTRL_JUMP_EN
        op = c_OP_J; #1;
        checks++; if (bus16.state !== 4'd9 || bus16.pc_write !== 1'b1 || bus16.pc_source !== 2'b10 || bus16.instr_done !== 1'b1) begin
            errors++; $display("FAIL jump_exec: got state=%0d pc_write=%0b pc_source=%0b instr_done=%0b want 9/1/10/1", bus16.state, bus16.pc_write, bus16.pc_source, bus16.instr_done);
        end
        step;
        exp_count++;
`endif
        checks++; if (bus16.state !== 4'd0 || bus16.instr_count !== 16'(exp_count)) begin
            errors++; $display("FAIL jump_end: got state=%0d count=%0d want 0/%0d", bus16.state, bus16.instr_count, exp_count);
        end
    endtask

    task automatic test_reset_stalled_read;
        for (int i = 0; i < 5; i++) begin
            op = c_OP_LW; ready = (i < 3); #1;
            checks++; if (bus16.state !== ((i < 3) ? 4'(i) : 4'd3) || bus16.reg_write !== 1'b0) begin
                errors++; $display("FAIL rd_stall[%0d]: got state=%0d reg_write=%0b", i, bus16.state, bus16.reg_write);
            end
            step;
        end
        rst = 1'b1; ready = 1'b0; #1;
        checks++; if (bus16.state !== 4'd3) begin errors++; $display("FAIL rd_rst_sync: got state=%0d want 3", bus16.state); end
        step;
        checks++; if (bus16.state !== 4'd0 || bus16.instr_count !== 16'd0 || bus4.instr_count !== 4'd0 || bus16.reg_write !== 1'b0) begin
            errors++; $display("FAIL rd_rst: got state=%0d count=%0d count4=%0d reg_write=%0b want 0/0/0/0", bus16.state, bus16.instr_count, bus4.instr_count, bus16.reg_write);
        end
        rst = 1'b0; ready = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_wrap;
        logic [3:0] st [0:3];
        st = '{4'd0, 4'd1, 4'd6, 4'd7};
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 4; c++) begin
                op = c_OP_R; ready = 1'b1; #1;
                checks++; if (bus4.state !== st[c]) begin errors++; $display("FAIL wrap_state[%0d][%0d]: got %0d want %0d", k, c, bus4.state, st[c]); end
                step;
            end
            exp_count++;
            checks++; if (bus4.instr_count !== 4'((k + 1) % 16)) begin
                errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", k, bus4.instr_count, (k + 1) % 16);
            end
        end
        checks++; if (bus16.instr_count !== 16'(exp_count)) begin errors++; $display("FAIL wrap_count16: got %0d want %0d", bus16.instr_count, exp_count); end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_sw_stall;
        test_illegal;
        test_alu_branch;
        test_jump;
        test_reset_stalled_read;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter (legal range 4..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port instr_op, input, 6, opcode field of the instruction register (held stable externally between fetches).
REQ-005 SHALL have port mem_ready, input, 1, memory handshake; high = the current read/write completes this cycle.
REQ-006 SHALL have outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst, each 1 bit, the datapath control strobes.
REQ-007 SHALL have outputs pc_source (2), alu_op (2) and alu_src_b (2), the datapath mux/ALU selects.
REQ-008 SHALL have outputs state (4), current FSM state; instr_done (1), last cycle of an instruction; illegal_op (1), unrecognised opcode; instr_count (CNT_W), retired instructions.

Function
REQ-009 SHALL be a Moore FSM with 4-bit encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-010 SHALL drive every output not listed for a state to 0.
REQ-011 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-012 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by instr_op: 000000 to EXECUTE, 100011/101011 to MEM_ADDR, 000100 to BRANCH, 001000 to ADDI_EX, 000010 to JUMP (see REQ-024), any other to FETCH.
REQ-013 DECODE with an unrecognised opcode SHALL assert illegal_op in that cycle only; no register or memory strobe is asserted.
REQ-014 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; 100011 goes to MEM_RD, otherwise to MEM_WR.
REQ-015 MEM_RD: mem_read=1, i_or_d=1; stay until mem_ready=1, then go to MEM_WB. MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; go to FETCH.
REQ-016 MEM_WR: mem_write=1, i_or_d=1; stay until mem_ready=1, then go to FETCH.
REQ-017 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; go to R_WB. R_WB: reg_dst=1, mem_to_reg=0, reg_write=1; go to FETCH.
REQ-018 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; go to FETCH.
REQ-019 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; go to ADDI_WB. ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1; go to FETCH.
REQ-020 JUMP: pc_write=1, pc_source=10; go to FETCH.
REQ-021 instr_done SHALL be 1 in MEM_WB, R_WB, BRANCH, JUMP and ADDI_WB, and in MEM_WR when mem_ready=1; it SHALL be 0 otherwise, including on the illegal-opcode path.
REQ-022 instr_count SHALL increment by 1 at each edge where instr_done=1, and SHALL wrap from 2^CNT_W-1 to 0 without saturating.
REQ-023 Latency in cycles with mem_ready held high: R-type/addi 4, lw 5, sw 4, beq 3, j 3; each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.

Configuration
REQ-024 Macro CTRL_JUMP_EN SHALL control jump support.
- Defined: opcode 000010 goes to JUMP.
- Undefined: the JUMP state is absent, opcode 000010 is illegal (REQ-013) and state code 9 is handled as in REQ-009.

Reset
REQ-025 rst=1 at a rising edge SHALL set state=FETCH and instr_count=0, overriding mem_ready and any in-progress instruction, including a stalled MEM_RD or MEM_WR.
REQ-026 After reset, outputs SHALL equal the FETCH decode: mem_read=1, alu_src_b=01, ir_write=pc_write=mem_ready, all other outputs 0.
REQ-027 rst held high for several cycles SHALL keep state=FETCH with no writes other than the mem_ready-qualified fetch strobes.

Verification
REQ-028 Reset, then lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_count=1.
REQ-029 sw with mem_ready=0 for 3 cycles in MEM_WR -> state 5 held 4 cycles, mem_write=1 throughout, instr_done=1 only in the final cycle.
REQ-030 Opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; instr_count unchanged, reg_write and mem_write stay 0.
REQ-031 CNT_W=4, 16 R-type instructions -> instr_count wraps 15 to 0; each takes 4 cycles.
REQ-032 rst=1 during a stalled MEM_RD -> state=0 and instr_count=0 the next cycle; reg_write never pulses.
REQ-033 Opcode 000010 -> with CTRL_JUMP_EN: state 9, pc_write=1, pc_source=10; without it: illegal_op=1.
